// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, owner codes and FSM encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int BYTE_SEL = 4;

   localparam logic [DATA_W-1:0] ZERO32 = 32'h0000_0000;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN_M0 = 2'd1,
      ST_OWN_M1 = 2'd2
   } arb_state_e;

   // Hold counter increments but sticks at its maximum rather than wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Round-robin ownership FSM with bounded hold time; grants are decoded from
// the current owner state and the live request lines.
module dmem_arb_fsm
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic clk,
   input  logic rst,
   input  logic i_m0_req,
   input  logic i_m1_req,
   output logic o_m0_gnt,
   output logic o_m1_gnt
);

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

   arb_state_e r_state;
   arb_state_e w_next_state;
   logic       r_last_owner;
   logic       w_next_last_owner;
   logic [7:0] r_hold_cnt;
   logic [7:0] w_next_hold_cnt;

   // State, last owner and hold counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_last_owner <= OWNER_M1;
         r_hold_cnt   <= 8'd0;
      end else begin
         r_state      <= w_next_state;
         r_last_owner <= w_next_last_owner;
         r_hold_cnt   <= w_next_hold_cnt;
      end
   end

   // Next-state selection; entering an owner state restarts the hold count.
   always_comb begin
      w_next_state      = r_state;
      w_next_last_owner = r_last_owner;
      w_next_hold_cnt   = r_hold_cnt;
      case (r_state)
         ST_IDLE: begin
            if (i_m0_req && i_m1_req) begin
               if (r_last_owner == OWNER_M1) begin
                  w_next_state      = ST_OWN_M0;
                  w_next_last_owner = OWNER_M0;
               end else begin
                  w_next_state      = ST_OWN_M1;
                  w_next_last_owner = OWNER_M1;
               end
               w_next_hold_cnt = 8'd0;
            end else if (i_m0_req) begin
               w_next_state      = ST_OWN_M0;
               w_next_last_owner = OWNER_M0;
               w_next_hold_cnt   = 8'd0;
            end else if (i_m1_req) begin
               w_next_state      = ST_OWN_M1;
               w_next_last_owner = OWNER_M1;
               w_next_hold_cnt   = 8'd0;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         // >= rather than == keeps the wait bound after a long solo burst.
         ST_OWN_M0: begin
            if (!i_m0_req || (i_m1_req && (r_hold_cnt >= HOLD_LIMIT))) begin
               if (i_m1_req) begin
                  w_next_state      = ST_OWN_M1;
                  w_next_last_owner = OWNER_M1;
                  w_next_hold_cnt   = 8'd0;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end else begin
               w_next_hold_cnt = sat_inc8(r_hold_cnt);
            end
         end
         ST_OWN_M1: begin
            if (!i_m1_req || (i_m0_req && (r_hold_cnt >= HOLD_LIMIT))) begin
               if (i_m0_req) begin
                  w_next_state      = ST_OWN_M0;
                  w_next_last_owner = OWNER_M0;
                  w_next_hold_cnt   = 8'd0;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end else begin
               w_next_hold_cnt = sat_inc8(r_hold_cnt);
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign o_m0_gnt = (r_state == ST_OWN_M0) & i_m0_req;
   assign o_m1_gnt = (r_state == ST_OWN_M1) & i_m1_req;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: slave-port mux and read-response routing
// around the ownership FSM.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [BYTE_SEL-1:0] m0_byte_mask,
   input  logic                m0_un_sign,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [BYTE_SEL-1:0] m1_byte_mask,
   input  logic                m1_un_sign,
   output logic                m0_gnt_o,
   output logic                m1_gnt_o,
   output logic                m0_rvalid_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   output logic                s_rw_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [DATA_W-1:0]   s_wdata_o,
   output logic [BYTE_SEL-1:0] s_byte_mask_o,
   output logic                s_un_sign_o,
   input  logic [DATA_W-1:0]   s_rdata
);

   logic w_m0_gnt;
   logic w_m1_gnt;
   logic w_gnt_read;
   logic r_rd_pend;
   logic r_rd_owner;

   dmem_arb_fsm #(
      .MAX_HOLD (MAX_HOLD)
   ) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .i_m0_req (m0_req),
      .i_m1_req (m1_req),
      .o_m0_gnt (w_m0_gnt),
      .o_m1_gnt (w_m1_gnt)
   );

   assign m0_gnt_o = w_m0_gnt;
   assign m1_gnt_o = w_m1_gnt;

   // Slave port carries the granted beat only; idle cycles drive all zeros.
   always_comb begin
      s_rw_o        = MEM_READ;
      s_addr_o      = ZERO32;
      s_wdata_o     = ZERO32;
      s_byte_mask_o = {BYTE_SEL{1'b0}};
      s_un_sign_o   = 1'b0;
      if (w_m0_gnt) begin
         s_rw_o        = m0_we;
         s_addr_o      = m0_addr;
         s_wdata_o     = m0_wdata;
         s_byte_mask_o = m0_byte_mask;
         s_un_sign_o   = m0_un_sign;
      end else if (w_m1_gnt) begin
         s_rw_o        = m1_we;
         s_addr_o      = m1_addr;
         s_wdata_o     = m1_wdata;
         s_byte_mask_o = m1_byte_mask;
         s_un_sign_o   = m1_un_sign;
      end else begin
         s_rw_o        = MEM_READ;
         s_addr_o      = ZERO32;
      end
   end

   assign w_gnt_read = (w_m0_gnt | w_m1_gnt) & (s_rw_o == MEM_READ);

   // Remember which master owns the read whose data arrives next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_pend  <= 1'b0;
         r_rd_owner <= OWNER_M0;
      end else begin
         r_rd_pend <= w_gnt_read;
         if (w_gnt_read) begin
            r_rd_owner <= w_m1_gnt ? OWNER_M1 : OWNER_M0;
         end else begin
            r_rd_owner <= r_rd_owner;
         end
      end
   end

   assign m0_rvalid_o = r_rd_pend & (r_rd_owner == OWNER_M0);
   assign m1_rvalid_o = r_rd_pend & (r_rd_owner == OWNER_M1);
   assign m0_rdata_o  = m0_rvalid_o ? s_rdata : ZERO32;
   assign m1_rdata_o  = m1_rvalid_o ? s_rdata : ZERO32;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scenarios plus a randomized run against a cycle-level reference
// model of the arbitration rules.
module tb_dmem_arbiter;

   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_v;
   logic [1:0]  we_v;
   logic [1:0]  uns_v;
   logic [31:0] addr_v  [2];
   logic [31:0] wdata_v [2];
   logic [3:0]  mask_v  [2];
   logic [31:0] s_rdata;

   logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_rw_o, s_un_sign_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [3:0]  s_byte_mask_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk           (clk),
      .rst           (rst),
      .m0_req        (req_v[0]),
      .m0_we         (we_v[0]),
      .m0_addr       (addr_v[0]),
      .m0_wdata      (wdata_v[0]),
      .m0_byte_mask  (mask_v[0]),
      .m0_un_sign    (uns_v[0]),
      .m1_req        (req_v[1]),
      .m1_we         (we_v[1]),
      .m1_addr       (addr_v[1]),
      .m1_wdata      (wdata_v[1]),
      .m1_byte_mask  (mask_v[1]),
      .m1_un_sign    (uns_v[1]),
      .m0_gnt_o      (m0_gnt_o),
      .m1_gnt_o      (m1_gnt_o),
      .m0_rvalid_o   (m0_rvalid_o),
      .m1_rvalid_o   (m1_rvalid_o),
      .m0_rdata_o    (m0_rdata_o),
      .m1_rdata_o    (m1_rdata_o),
      .s_rw_o        (s_rw_o),
      .s_addr_o      (s_addr_o),
      .s_wdata_o     (s_wdata_o),
      .s_byte_mask_o (s_byte_mask_o),
      .s_un_sign_o   (s_un_sign_o),
      .s_rdata       (s_rdata)
   );

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_v = 2'b00;
      we_v  = 2'b00;
      uns_v = 2'b00;
      for (int x = 0; x < 2; x++) begin
         addr_v[x]  = 32'h0;
         wdata_v[x] = 32'h0;
         mask_v[x]  = 4'h0;
      end
   endtask

   task automatic go_idle();
      clear_inputs();
      next_cyc();
      next_cyc();
   endtask

   task automatic reset_pulse();
      clear_inputs();
      rst = 1'b0;
      next_cyc();
      rst = 1'b1;
      next_cyc();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst        = 1'b0;
      req_v      = 2'b11;
      addr_v[0]  = 32'h1234_5678;
      addr_v[1]  = 32'h0000_0ABC;
      wdata_v[0] = 32'hFFFF_0000;
      mask_v[1]  = 4'hF;
      we_v       = 2'b11;
      s_rdata    = 32'hA5A5_5A5A;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_rw_o, s_un_sign_o} !== 6'b0)
         $display("FAIL reset_ctrl got=%b exp=000000",
                  {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, s_rw_o, s_un_sign_o});
      else n_pass++;
      n_checks++;
      if ({s_addr_o, s_wdata_o, s_byte_mask_o} !== 68'h0)
         $display("FAIL reset_slave got=%h/%h/%h exp=0", s_addr_o, s_wdata_o, s_byte_mask_o);
      else n_pass++;
      n_checks++;
      if ({m0_rdata_o, m1_rdata_o} !== 64'h0)
         $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata_o, m1_rdata_o);
      else n_pass++;
      n_checks++;
      if (dut.u_fsm.r_last_owner !== 1'b1)
         $display("FAIL reset_last_owner got=%b exp=1", dut.u_fsm.r_last_owner);
      else n_pass++;
      clear_inputs();
      next_cyc();
      rst = 1'b1;
      next_cyc();
   endtask

   task automatic test_single_m0();
      logic exp_g, exp_v;
      we_v[0]   = 1'b0;
      addr_v[0] = 32'h0000_0100;
      for (int c = 0; c < 6; c++) begin
         req_v[0] = (c <= 3);
         s_rdata  = $urandom;
         @(negedge clk);
         exp_g = (c >= 1) && (c <= 3);
         exp_v = (c >= 2) && (c <= 4);
         n_checks++;
         if ({m0_gnt_o, m1_gnt_o, s_rw_o} !== {exp_g, 1'b0, 1'b0})
            $display("FAIL single_gnt c=%0d got=%b exp=%b", c, {m0_gnt_o, m1_gnt_o, s_rw_o}, {exp_g, 2'b00});
         else n_pass++;
         n_checks++;
         if (s_addr_o !== (exp_g ? 32'h0000_0100 : 32'h0))
            $display("FAIL single_addr c=%0d got=%h exp=%h", c, s_addr_o, exp_g ? 32'h100 : 32'h0);
         else n_pass++;
         n_checks++;
         if ({m0_rvalid_o, m1_rvalid_o} !== {exp_v, 1'b0})
            $display("FAIL single_rvalid c=%0d got=%b exp=%b", c, {m0_rvalid_o, m1_rvalid_o}, {exp_v, 1'b0});
         else n_pass++;
         n_checks++;
         if ({m0_rdata_o, m1_rdata_o} !== {(exp_v ? s_rdata : 32'h0), 32'h0})
            $display("FAIL single_rdata c=%0d got=%h/%h exp=%h/0", c, m0_rdata_o, m1_rdata_o, exp_v ? s_rdata : 32'h0);
         else n_pass++;
         next_cyc();
      end
      go_idle();
   endtask

   task automatic test_tie_at_reset();
      reset_pulse();
      addr_v[0] = 32'h0000_0010;
      addr_v[1] = 32'h0000_0020;
      req_v     = 2'b11;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b00)
         $display("FAIL tie_c0 got=%b exp=00", {m0_gnt_o, m1_gnt_o});
      else n_pass++;
      next_cyc();
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, m1_gnt_o, s_addr_o} !== {2'b10, 32'h0000_0010})
         $display("FAIL tie_first got=%b addr=%h exp=10 addr=10", {m0_gnt_o, m1_gnt_o}, s_addr_o);
      else n_pass++;
      n_checks++;
      if (dut.u_fsm.r_last_owner !== 1'b0)
         $display("FAIL tie_last_owner got=%b exp=0", dut.u_fsm.r_last_owner);
      else n_pass++;
      next_cyc();
      req_v[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o} !== 3'b001)
         $display("FAIL tie_drop got=%b exp=001", {m0_gnt_o, m1_gnt_o, m0_rvalid_o});
      else n_pass++;
      next_cyc();
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, m1_gnt_o, s_addr_o} !== {2'b01, 32'h0000_0020})
         $display("FAIL tie_second got=%b addr=%h exp=01 addr=20", {m0_gnt_o, m1_gnt_o}, s_addr_o);
      else n_pass++;
      next_cyc();
      req_v[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({m1_rvalid_o, m0_rvalid_o} !== 2'b10)
         $display("FAIL tie_m1_rvalid got=%b exp=10", {m1_rvalid_o, m0_rvalid_o});
      else n_pass++;
      go_idle();
   endtask

   task automatic test_starvation();
      logic [1:0] exp_g;
      for (int c = 0; c < 8; c++) begin
         req_v[0] = 1'b1;
         req_v[1] = (c >= 2) && (c <= 5);
         @(negedge clk);
         exp_g = {(c == 5), ((c >= 1) && (c <= 4)) || (c == 7)};
         n_checks++;
         if ({m1_gnt_o, m0_gnt_o} !== exp_g)
            $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, {m1_gnt_o, m0_gnt_o}, exp_g);
         else n_pass++;
         next_cyc();
      end
      go_idle();
   endtask

   task automatic test_write_isolation();
      int rw_cycles = 0;
      logic on;
      we_v[1]    = 1'b1;
      addr_v[1]  = 32'h0000_0040;
      wdata_v[1] = 32'hDEAD_BEEF;
      mask_v[1]  = 4'b0011;
      uns_v[1]   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         req_v[1] = (c <= 1);
         @(negedge clk);
         on = (c == 1);
         if (s_rw_o === 1'b1) rw_cycles++;
         n_checks++;
         if ({m1_gnt_o, s_rw_o, s_un_sign_o, m1_rvalid_o} !== {on, on, on, 1'b0})
            $display("FAIL wr_ctrl c=%0d got=%b exp=%b", c, {m1_gnt_o, s_rw_o, s_un_sign_o, m1_rvalid_o}, {on, on, on, 1'b0});
         else n_pass++;
         n_checks++;
         if ({s_addr_o, s_wdata_o, s_byte_mask_o} !== (on ? {32'h40, 32'hDEAD_BEEF, 4'b0011} : 68'h0))
            $display("FAIL wr_bus c=%0d got=%h/%h/%b", c, s_addr_o, s_wdata_o, s_byte_mask_o);
         else n_pass++;
         next_cyc();
      end
      n_checks++;
      if (rw_cycles != 1)
         $display("FAIL wr_count got=%0d exp=1", rw_cycles);
      else n_pass++;
      go_idle();
   endtask

   task automatic test_mixed_handover();
      logic exp_g0, exp_g1, exp_v0;
      we_v[1]    = 1'b1;
      addr_v[1]  = 32'h0000_0300;
      wdata_v[1] = 32'h1357_9BDF;
      mask_v[1]  = 4'hF;
      for (int c = 0; c < 7; c++) begin
         req_v[0]  = (c <= 4);
         addr_v[0] = 32'h0000_0200 + 32'(4 * c);
         req_v[1]  = (c >= 1) && (c <= 5);
         s_rdata   = $urandom;
         @(negedge clk);
         exp_g0 = (c >= 1) && (c <= 4);
         exp_g1 = (c == 5);
         exp_v0 = (c >= 2) && (c <= 5);
         n_checks++;
         if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o} !== {exp_g0, exp_g1, exp_v0})
            $display("FAIL mixed c=%0d got=%b exp=%b", c, {m0_gnt_o, m1_gnt_o, m0_rvalid_o}, {exp_g0, exp_g1, exp_v0});
         else n_pass++;
         if (c == 5) begin
            n_checks++;
            if ({s_rw_o, s_wdata_o, m0_rdata_o} !== {1'b1, 32'h1357_9BDF, s_rdata})
               $display("FAIL mixed_overlap got=%b/%h/%h exp=1/13579bdf/%h", s_rw_o, s_wdata_o, m0_rdata_o, s_rdata);
            else n_pass++;
         end
         next_cyc();
      end
      go_idle();
   endtask

   task automatic test_reset_mid_read();
      addr_v[0] = 32'h0000_0080;
      req_v[0]  = 1'b1;
      next_cyc();
      @(negedge clk);
      n_checks++;
      if (m0_gnt_o !== 1'b1)
         $display("FAIL midrst_gnt got=%b exp=1", m0_gnt_o);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({m0_gnt_o, m1_gnt_o, s_rw_o, s_addr_o} !== 35'h0)
         $display("FAIL midrst_async got=%b addr=%h exp=0", {m0_gnt_o, m1_gnt_o, s_rw_o}, s_addr_o);
      else n_pass++;
      next_cyc();
      s_rdata = 32'hCAFE_F00D;
      n_checks++;
      if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o} !== 66'h0)
         $display("FAIL midrst_drop got=%b/%b/%h/%h exp=0", m0_rvalid_o, m1_rvalid_o, m0_rdata_o, m1_rdata_o);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, m0_rvalid_o} !== 2'b00)
         $display("FAIL midrst_release got=%b exp=00", {m0_gnt_o, m0_rvalid_o});
      else n_pass++;
      next_cyc();
      @(negedge clk);
      n_checks++;
      if ({m0_gnt_o, s_addr_o} !== {1'b1, 32'h0000_0080})
         $display("FAIL midrst_regrant got=%b addr=%h exp=1 addr=80", m0_gnt_o, s_addr_o);
      else n_pass++;
      go_idle();
   endtask

   task automatic test_random();
      int         owner, beats, last, pend_who, g, nxt;
      bit         pend;
      logic [1:0] eg, last_eg, erv;
      int         waited [2];
      logic [69:0] exp_bus;
      reset_pulse();
      owner = -1; beats = 0; last = 1; pend = 1'b0; pend_who = 0;
      last_eg = 2'b00;
      waited[0] = 0; waited[1] = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int x = 0; x < 2; x++) begin
            if (!req_v[x] || last_eg[x]) begin
               if ($urandom_range(0, 99) < 60) begin
                  req_v[x]   = 1'b1;
                  we_v[x]    = 1'($urandom_range(0, 1));
                  uns_v[x]   = 1'($urandom_range(0, 1));
                  addr_v[x]  = $urandom;
                  wdata_v[x] = $urandom;
                  mask_v[x]  = 4'($urandom_range(0, 15));
               end else begin
                  req_v[x] = 1'b0;
               end
            end
         end
         s_rdata = $urandom;
         @(negedge clk);
         eg[0] = (owner == 0) && req_v[0];
         eg[1] = (owner == 1) && req_v[1];
         g = eg[0] ? 0 : (eg[1] ? 1 : -1);
         erv[0] = pend && (pend_who == 0);
         erv[1] = pend && (pend_who == 1);
         exp_bus = (g >= 0) ? {we_v[g], uns_v[g], addr_v[g], wdata_v[g], mask_v[g]} : 70'h0;
         n_checks++;
         if ({m1_gnt_o, m0_gnt_o} !== eg)
            $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {m1_gnt_o, m0_gnt_o}, eg);
         else n_pass++;
         n_checks++;
         if ({m1_rvalid_o, m0_rvalid_o} !== erv)
            $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, {m1_rvalid_o, m0_rvalid_o}, erv);
         else n_pass++;
         n_checks++;
         if ({m1_rdata_o, m0_rdata_o} !== {(erv[1] ? s_rdata : 32'h0), (erv[0] ? s_rdata : 32'h0)})
            $display("FAIL rnd_rdata cyc=%0d got=%h/%h", cyc, m1_rdata_o, m0_rdata_o);
         else n_pass++;
         n_checks++;
         if ({s_rw_o, s_un_sign_o, s_addr_o, s_wdata_o, s_byte_mask_o} !== exp_bus)
            $display("FAIL rnd_slave cyc=%0d got=%h exp=%h", cyc,
                     {s_rw_o, s_un_sign_o, s_addr_o, s_wdata_o, s_byte_mask_o}, exp_bus);
         else n_pass++;
         for (int x = 0; x < 2; x++) begin
            if (req_v[x]) begin
               if ((x == 0) ? m0_gnt_o : m1_gnt_o) waited[x] = 0;
               else waited[x]++;
               n_checks++;
               if (waited[x] > MAX_HOLD + 1)
                  $display("FAIL rnd_wait m%0d cyc=%0d got=%0d exp<=%0d", x, cyc, waited[x], MAX_HOLD + 1);
               else n_pass++;
            end
         end
         // advance the reference model by one clock
         if (g >= 0) begin
            pend = !we_v[g];
            pend_who = g;
         end else begin
            pend = 1'b0;
         end
         nxt = owner;
         if (owner < 0) begin
            if (req_v[0] && req_v[1]) nxt = 1 - last;
            else if (req_v[0])        nxt = 0;
            else if (req_v[1])        nxt = 1;
            else                      nxt = -1;
         end else if (!req_v[owner]) begin
            nxt = req_v[1 - owner] ? (1 - owner) : -1;
         end else if (req_v[1 - owner] && (beats >= MAX_HOLD - 1)) begin
            nxt = 1 - owner;
         end else if (beats < 255) begin
            beats++;
         end
         if (nxt >= 0 && nxt != owner) begin
            last  = nxt;
            beats = 0;
         end
         owner   = nxt;
         last_eg = eg;
         next_cyc();
      end
      go_idle();
   endtask

   initial begin
      rst     = 1'b0;
      s_rdata = 32'h0;
      clear_inputs();
      test_reset();
      test_single_m0();
      test_tie_at_reset();
      test_starvation();
      test_write_isolation();
      test_mixed_handover();
      test_reset_mid_read();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
